// File: rtl/run_length_detector_if.sv
// Sample/flag bundle for run_length_detector. det_clr/det_count exist only when
// RUN_DET_COUNT_EN is defined.
interface run_length_detector_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned DET_W = 8
);
  logic             in_valid;
  logic             in;
  logic             mode_restart;
  logic             out;
  logic             out_zero;
  logic             out_one;
  logic [CNT_W-1:0] run_cnt;
`ifdef RUN_DET_COUNT_EN
  logic             det_clr;
  logic [DET_W-1:0] det_count;

  modport master (
    output in_valid, in, mode_restart, det_clr,
    input  out, out_zero, out_one, run_cnt, det_count
  );
  modport slave (
    input  in_valid, in, mode_restart, det_clr,
    output out, out_zero, out_one, run_cnt, det_count
  );
`else
  modport master (
    output in_valid, in, mode_restart,
    input  out, out_zero, out_one, run_cnt
  );
  modport slave (
    input  in_valid, in, mode_restart,
    output out, out_zero, out_one, run_cnt
  );

  if (DET_W == 0) begin : g_det_w_check
    $error("DET_W must be nonzero");
  end
`endif
endinterface

// File: rtl/run_length_detector.sv
// Detects RUN_LEN consecutive identical valid samples (all-0 or all-1), sticky or restart mode.
// Optional saturating detection-event counter enabled by defining RUN_DET_COUNT_EN.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned DET_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  run_length_detector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun0, StRun1} state_e;

  localparam logic [CNT_W-1:0] RunLenC = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  if (RUN_LEN < 1 || RUN_LEN >= (2 ** CNT_W) || DET_W < 1) begin : g_param_check
    $error("RUN_LEN must be in 1..2**CNT_W-1 and DET_W nonzero");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.in_valid) begin
      case (state_q)
        StRun0, StRun1: begin
          if (bus.in == (state_q == StRun1)) begin
            if (cnt_q < RunLenC) begin
              cnt_d = cnt_q + CntOne;
            end else if (bus.mode_restart) begin
              cnt_d = CntOne;
            end
          end else begin
            // Polarity change starts the opposite run directly, no pass through idle.
            state_d = bus.in ? StRun1 : StRun0;
            cnt_d   = CntOne;
          end
        end
        default: begin
          state_d = bus.in ? StRun1 : StRun0;
          cnt_d   = CntOne;
        end
      endcase
    end
  end

  always_comb begin
    bus.out_zero = (state_q == StRun0) && (cnt_q == RunLenC);
    bus.out_one  = (state_q == StRun1) && (cnt_q == RunLenC);
    bus.out      = bus.out_zero | bus.out_one;
    bus.run_cnt  = cnt_q;
  end

`ifdef RUN_DET_COUNT_EN
  logic             det_event;
  logic [DET_W-1:0] det_q, det_d;

  // Sticky hold at RUN_LEN is not a new event, except for RUN_LEN=1 where every
  // consumed sample raises the flag.
  always_comb begin
    det_event = bus.in_valid && (cnt_d == RunLenC) &&
                !((state_d == state_q) && (cnt_q == RunLenC) && (RUN_LEN > 1));
    det_d = det_q;
    if (bus.det_clr) begin
      det_d = det_event ? DET_W'(1) : '0;
    end else if (det_event && (det_q != '1)) begin
      det_d = det_q + DET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_q <= '0;
    end else begin
      det_q <= det_d;
    end
  end

  assign bus.det_count = det_q;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector (RUN_LEN=4, CNT_W=3); covers the
// det_count feature as well when RUN_DET_COUNT_EN is defined.
module tb_run_length_detector;

  logic clk;
  logic reset;

  run_length_detector_if #(.CNT_W(3), .DET_W(8)) bus ();

  run_length_detector #(.RUN_LEN(4), .CNT_W(3), .DET_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef RUN_DET_COUNT_EN
  // Narrow counter copy sharing the same stimulus, to exercise saturation.
  run_length_detector_if #(.CNT_W(3), .DET_W(2)) bus2 ();
  assign bus2.in_valid     = bus.in_valid;
  assign bus2.in           = bus.in;
  assign bus2.mode_restart = bus.mode_restart;
  assign bus2.det_clr      = bus.det_clr;

  run_length_detector #(.RUN_LEN(4), .CNT_W(3), .DET_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );
`endif

  typedef struct {
    int tag;
    int cnt;
    int z;
    int o;
    int det;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   tag_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  // Monitor: after each clock edge or asynchronous reset, compare every queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("run_cnt", e.tag, int'(bus.run_cnt), e.cnt);
        chk("out_zero", e.tag, int'(bus.out_zero), e.z);
        chk("out_one", e.tag, int'(bus.out_one), e.o);
        chk("out", e.tag, int'(bus.out), e.z | e.o);
`ifdef RUN_DET_COUNT_EN
        chk("det_count", e.tag, int'(bus.det_count), e.det);
        chk("det_count_w2", e.tag, int'(bus2.det_count), (e.det > 3) ? 3 : e.det);
`endif
      end
    end
  end

  task automatic push(input int cnt, input int z, input int o, input int det);
    exp_t e;
    tag_n++;
    e.tag = tag_n;
    e.cnt = cnt;
    e.z   = z;
    e.o   = o;
    e.det = det;
    q.push_back(e);
  endtask

  // One edge of stimulus, with the state expected just after that edge.
  task automatic smp(input bit v, input bit b, input bit m, input bit clr,
                     input int cnt, input int z, input int o, input int det);
    @(negedge clk);
    bus.in_valid     = v;
    bus.in           = b;
    bus.mode_restart = m;
`ifdef RUN_DET_COUNT_EN
    bus.det_clr      = clr;
`else
    if (clr) tag_n = tag_n + 0;
`endif
    push(cnt, z, o, det);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    tag_n            = 0;
    reset            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in           = 1'b0;
    bus.mode_restart = 1'b0;
`ifdef RUN_DET_COUNT_EN
    bus.det_clr      = 1'b0;
`endif
    @(negedge clk);
    push(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    smp(0, 0, 0, 0, 0, 0, 0, 0);

    // Sticky zeros: count up, flag after the 4th, hold for 3 more.
    smp(1, 0, 0, 0, 1, 0, 0, 0);
    smp(1, 0, 0, 0, 2, 0, 0, 0);
    smp(1, 0, 0, 0, 3, 0, 0, 0);
    smp(1, 0, 0, 0, 4, 1, 0, 1);
    smp(1, 0, 0, 0, 4, 1, 0, 1);
    smp(1, 0, 0, 0, 4, 1, 0, 1);
    smp(1, 0, 0, 0, 4, 1, 0, 1);

    // 1,1,1,0,1,1,1,1
    smp(1, 1, 0, 0, 1, 0, 0, 1);
    smp(1, 1, 0, 0, 2, 0, 0, 1);
    smp(1, 1, 0, 0, 3, 0, 0, 1);
    smp(1, 0, 0, 0, 1, 0, 0, 1);
    smp(1, 1, 0, 0, 1, 0, 0, 1);
    smp(1, 1, 0, 0, 2, 0, 0, 1);
    smp(1, 1, 0, 0, 3, 0, 0, 1);
    smp(1, 1, 0, 0, 4, 0, 1, 2);
    smp(0, 0, 0, 0, 4, 0, 1, 2);

    // Restart mode, 8 ones: flag only after the 4th and 8th.
    smp(1, 1, 1, 0, 1, 0, 0, 2);
    smp(1, 1, 1, 0, 2, 0, 0, 2);
    smp(1, 1, 1, 0, 3, 0, 0, 2);
    smp(1, 1, 1, 0, 4, 0, 1, 3);
    smp(1, 1, 1, 0, 1, 0, 0, 3);
    smp(1, 1, 1, 0, 2, 0, 0, 3);
    smp(1, 1, 1, 0, 3, 0, 0, 3);
    smp(1, 1, 1, 0, 4, 0, 1, 4);

    // 3 zeros, 5-cycle invalid gap with toggling data, then one zero.
    smp(1, 0, 0, 0, 1, 0, 0, 4);
    smp(1, 0, 0, 0, 2, 0, 0, 4);
    smp(1, 0, 0, 0, 3, 0, 0, 4);
    for (int i = 0; i < 5; i++) smp(0, i[0] ^ 1'b1, i[1], 0, 3, 0, 0, 4);
    smp(1, 0, 0, 0, 4, 1, 0, 5);

    // Restart reload, then mode 1->0 mid-run continues the count.
    smp(1, 0, 1, 0, 1, 0, 0, 5);
    smp(1, 0, 1, 0, 2, 0, 0, 5);
    smp(1, 0, 0, 0, 3, 0, 0, 5);
    smp(1, 0, 0, 0, 4, 1, 0, 6);
    smp(1, 0, 0, 0, 4, 1, 0, 6);

    // Asynchronous reset mid-cycle with run_cnt=3.
    smp(1, 1, 0, 0, 1, 0, 0, 6);
    smp(1, 1, 0, 0, 2, 0, 0, 6);
    smp(1, 1, 0, 0, 3, 0, 0, 6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    push(0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    smp(1, 1, 0, 0, 1, 0, 0, 0);
    smp(1, 1, 0, 0, 2, 0, 0, 0);
    smp(1, 1, 0, 0, 3, 0, 0, 0);
    smp(1, 1, 0, 0, 4, 0, 1, 1);
    for (int k = 1; k <= 4; k++) smp(1, 0, 0, 0, k, (k == 4) ? 1 : 0, 0, (k == 4) ? 2 : 1);
    for (int k = 1; k <= 6; k++) smp(1, 1, 0, 0, (k > 4) ? 4 : k, 0, (k >= 4) ? 1 : 0,
                                     (k >= 4) ? 3 : 2);

    // det_clr coinciding with an event, then a lone clear.
    smp(1, 0, 0, 0, 1, 0, 0, 3);
    smp(1, 0, 0, 0, 2, 0, 0, 3);
    smp(1, 0, 0, 0, 3, 0, 0, 3);
    smp(1, 0, 0, 1, 4, 1, 0, 1);
    smp(0, 0, 0, 1, 4, 1, 0, 0);

    // Five alternating runs: 5 events, narrow counter saturates at 3.
    for (int g = 0; g < 5; g++) begin
      for (int k = 1; k <= 4; k++) begin
        smp(1, (g % 2) == 0, 0, 0, k,
            ((g % 2) == 1 && k == 4) ? 1 : 0,
            ((g % 2) == 0 && k == 4) ? 1 : 0,
            (k == 4) ? g + 1 : g);
      end
    end

    smp(0, 0, 0, 0, 4, 0, 1, 5);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 0, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
